// File: rtl/inst_fetch_stage.sv
// Instruction fetch stage: owns the PC, buffers fetched words in a small FIFO and
// hands them to the core under a valid/stall handshake, with branch redirect and HALT.
module inst_fetch_stage #(
  parameter int          PC_WIDTH    = 8,
  parameter int          INST_WIDTH  = 16,
  parameter int          DEPTH       = 2,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [PC_WIDTH-1:0]   pc,
  input  logic [INST_WIDTH-1:0] inst_in,
  input  logic                  inst_in_valid,
  output logic [INST_WIDTH-1:0] inst_out,
  output logic [PC_WIDTH-1:0]   inst_out_pc,
  output logic                  inst_out_valid,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [PC_WIDTH-1:0]   branch_target,
  output logic                  halted
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {RUN, HALTED} state_t;

  state_t                state;
  logic [INST_WIDTH-1:0] mem_inst [DEPTH];
  logic [PC_WIDTH-1:0]   mem_pc   [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;

  logic                  pop;
  logic                  push;
  logic [AW-1:0]         rd_ptr_nxt;
  logic [CW-1:0]         remaining;
  logic                  is_halt;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    pop        = 1'b0;
    push       = 1'b0;
    rd_ptr_nxt = rd_ptr;
    remaining  = count;
    is_halt    = (inst_in[INST_WIDTH-1 -: 4] == HALT_OPCODE);
    pop        = inst_out_valid && !stall;
    push       = (state == RUN) && inst_in_valid && !branch_taken &&
                 ((count < CW'(DEPTH)) || pop);
    rd_ptr_nxt = rd_ptr + AW'(pop);
    // Entries left in storage after the pop, before this cycle's push lands.
    remaining  = count - CW'(pop);
  end

  // NOTE: storage is not reset; the pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_inst[wr_ptr] <= inst_in;
      mem_pc[wr_ptr]   <= pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc             <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      inst_out       <= '0;
      inst_out_pc    <= '0;
      inst_out_valid <= 1'b0;
      state          <= RUN;
      halted         <= 1'b0;
    end else if (branch_taken) begin
      pc             <= branch_target;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      inst_out_valid <= 1'b0;
      state          <= RUN;
      halted         <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        pc     <= pc + PC_WIDTH'(1);
        if (is_halt) begin
          state  <= HALTED;
          halted <= 1'b1;
        end
      end
      rd_ptr <= rd_ptr_nxt;
      count  <= count + CW'(push) - CW'(pop);

      // The head register reloads from storage, or takes the pushed word directly
      // when storage would otherwise be empty; with nothing left it holds its value.
      if (remaining != '0) begin
        inst_out       <= mem_inst[rd_ptr_nxt];
        inst_out_pc    <= mem_pc[rd_ptr_nxt];
        inst_out_valid <= 1'b1;
      end else if (push) begin
        inst_out       <= inst_in;
        inst_out_pc    <= pc;
        inst_out_valid <= 1'b1;
      end else begin
        inst_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Self-checking bench for inst_fetch_stage: a reference model of pc/halt feeds a
// scoreboard of {inst, pc} entries that are compared as the core pops them.
module tb_inst_fetch_stage;

  typedef struct packed {
    logic [15:0] inst;
    logic [7:0]  pc;
  } entry_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  pc;
  logic [15:0] inst_in;
  logic        inst_in_valid;
  logic [15:0] inst_out;
  logic [7:0]  inst_out_pc;
  logic        inst_out_valid;
  logic        stall;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic        halted;

  entry_t      sb[$];
  logic [7:0]  m_pc;
  logic        m_halted;
  logic        did_pop;
  entry_t      got_pop;
  entry_t      exp_pop;
  int          checks = 0;
  int          passes = 0;

  inst_fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .pc            (pc),
    .inst_in       (inst_in),
    .inst_in_valid (inst_in_valid),
    .inst_out      (inst_out),
    .inst_out_pc   (inst_out_pc),
    .inst_out_valid(inst_out_valid),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d passed=%0d", checks, passes);
    $fatal(1, "watchdog");
  end

  // One clock: drive inputs at the negedge, capture what the core pops, step the model.
  task automatic tick(input logic v, input logic st, input logic br,
                      input logic [7:0] tgt, input logic [15:0] word);
    bit p, q;
    reset         = 1'b0;
    inst_in_valid = v;
    inst_in       = v ? word : 16'hxxxx;
    stall         = st;
    branch_taken  = br;
    branch_target = tgt;
    p = (sb.size() > 0) && !st;
    q = !m_halted && v && !br && ((sb.size() < 2) || p);
    did_pop = p && !br;
    got_pop = {inst_out, inst_out_pc};
    exp_pop = '0;
    if (sb.size() > 0) exp_pop = sb[0];
    @(posedge clk);
    if (br) begin
      sb.delete();
      m_pc     = tgt;
      m_halted = 1'b0;
    end else begin
      if (p) void'(sb.pop_front());
      if (q) begin
        sb.push_back({word, m_pc});
        if (word[15:12] == 4'hF) m_halted = 1'b1;
        m_pc = m_pc + 8'd1;
      end
    end
    @(negedge clk);
  endtask

  task automatic apply_reset(input logic st, input logic v);
    reset         = 1'b1;
    stall         = st;
    inst_in_valid = v;
    inst_in       = 16'h1000;
    branch_taken  = 1'b0;
    branch_target = 8'h00;
    @(posedge clk);
    sb.delete();
    m_pc     = 8'h00;
    m_halted = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset(1'b0, 1'b0);
    apply_reset(1'b0, 1'b0);
    checks++; if (pc !== 8'h00) $display("FAIL reset_pc: got %h want 00", pc); else passes++;
    checks++; if (inst_out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", inst_out_valid); else passes++;
    checks++; if ({inst_out, inst_out_pc} !== 24'h0) $display("FAIL reset_out: got %h/%h want 0000/00", inst_out, inst_out_pc); else passes++;
    checks++; if (halted !== 1'b0) $display("FAIL reset_halted: got %b want 0", halted); else passes++;
  endtask

  task automatic test_stream();
    int n = 0;
    apply_reset(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 1'b0, 1'b0, 8'h00, 16'h1000 + 16'(m_pc));
      if (did_pop) begin
        checks++;
        if (got_pop !== entry_t'({16'h1000 + 16'(n), 8'(n)}))
          $display("FAIL stream_pop%0d: got %h want %h", n, got_pop, {16'h1000 + 16'(n), 8'(n)});
        else passes++;
        n++;
      end
      checks++; if (pc !== 8'(i + 1)) $display("FAIL stream_pc%0d: got %h want %h", i, pc, 8'(i + 1)); else passes++;
      checks++; if (inst_out_valid !== 1'b1) $display("FAIL stream_valid%0d: got %b want 1", i, inst_out_valid); else passes++;
    end
    for (int i = 0; i < 6 && sb.size() > 0; i++) begin
      tick(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
      if (did_pop) begin
        checks++; if (got_pop !== exp_pop) $display("FAIL stream_drain: got %h want %h", got_pop, exp_pop); else passes++;
        n++;
      end
    end
    checks++; if (n !== 6) $display("FAIL stream_count: got %0d pops want 6", n); else passes++;
    checks++; if (inst_out_valid !== 1'b0) $display("FAIL stream_empty: got %b want 0", inst_out_valid); else passes++;
  endtask

  task automatic test_stall();
    int n = 0;
    apply_reset(1'b0, 1'b0);
    for (int i = 0; i < 14; i++) begin
      tick(1'b1, (i >= 2 && i < 6), 1'b0, 8'h00, 16'h1000 + 16'(m_pc));
      if (did_pop) begin
        checks++;
        if (got_pop !== entry_t'({16'h1000 + 16'(n), 8'(n)}))
          $display("FAIL stall_seq%0d: got %h want %h", n, got_pop, {16'h1000 + 16'(n), 8'(n)});
        else passes++;
        n++;
      end
      if (i == 5) begin
        checks++; if (pc !== 8'h03) $display("FAIL stall_pc: got %h want 03", pc); else passes++;
        checks++; if ({inst_out, inst_out_pc} !== 24'h1001_01) $display("FAIL stall_head: got %h/%h want 1001/01", inst_out, inst_out_pc); else passes++;
      end
    end
    for (int i = 0; i < 6 && sb.size() > 0; i++) begin
      tick(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
      if (did_pop) begin
        checks++; if (got_pop !== exp_pop) $display("FAIL stall_drain: got %h want %h", got_pop, exp_pop); else passes++;
      end
    end
    checks++; if (sb.size() !== 0) $display("FAIL stall_timeout: %0d words never drained", sb.size()); else passes++;
  endtask

  task automatic test_branch();
    bit first = 1'b1;
    apply_reset(1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 8'h00, 16'h1000 + 16'(m_pc));
    tick(1'b1, 1'b1, 1'b0, 8'h00, 16'h1000 + 16'(m_pc));
    tick(1'b1, 1'b0, 1'b1, 8'h40, 16'h1000 + 16'(m_pc));
    checks++; if (inst_out_valid !== 1'b0) $display("FAIL branch_flush: got %b want 0", inst_out_valid); else passes++;
    checks++; if (pc !== 8'h40) $display("FAIL branch_pc: got %h want 40", pc); else passes++;
    for (int i = 0; i < 8; i++) begin
      tick((i < 3), 1'b0, 1'b0, 8'h00, 16'h1000 + 16'(m_pc));
      if (did_pop) begin
        checks++; if (got_pop !== exp_pop) $display("FAIL branch_pop: got %h want %h", got_pop, exp_pop); else passes++;
        if (first) begin
          checks++; if (got_pop.pc !== 8'h40) $display("FAIL branch_first: got pc %h want 40", got_pop.pc); else passes++;
          first = 1'b0;
        end
      end
    end
    checks++; if (first) $display("FAIL branch_nopop: got no word want pc 40"); else passes++;
  endtask

  task automatic test_wrap();
    logic [7:0] want [3] = '{8'hFE, 8'hFF, 8'h00};
    int n = 0;
    tick(1'b0, 1'b0, 1'b1, 8'hFE, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      tick((i < 3), 1'b0, 1'b0, 8'h00, 16'h1000 + 16'(m_pc));
      if (did_pop && n < 3) begin
        checks++;
        if (inst_out_pc !== want[n] && got_pop.pc !== want[n]) $display("FAIL wrap_pc%0d: got %h want %h", n, got_pop.pc, want[n]);
        else if (got_pop !== exp_pop) $display("FAIL wrap_word%0d: got %h want %h", n, got_pop, exp_pop);
        else passes++;
        n++;
      end
    end
    checks++; if (n !== 3) $display("FAIL wrap_count: got %0d pops want 3", n); else passes++;
  endtask

  task automatic test_halt();
    bit seen = 1'b0;
    apply_reset(1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      tick(1'b1, 1'b0, 1'b0, 8'h00, (m_pc == 8'h05) ? 16'hF123 : 16'h1000 + 16'(m_pc));
      if (did_pop) begin
        checks++; if (got_pop !== exp_pop) $display("FAIL halt_pop: got %h want %h", got_pop, exp_pop); else passes++;
        if (got_pop === entry_t'({16'hF123, 8'h05})) seen = 1'b1;
      end
      checks++; if (halted !== m_halted) $display("FAIL halt_flag%0d: got %b want %b", i, halted, m_halted); else passes++;
    end
    checks++; if (!seen) $display("FAIL halt_drain: got no F123/05 want F123/05"); else passes++;
    checks++; if (pc !== 8'h06) $display("FAIL halt_pc: got %h want 06", pc); else passes++;
    checks++; if (inst_out_valid !== 1'b0) $display("FAIL halt_empty: got %b want 0", inst_out_valid); else passes++;
    tick(1'b1, 1'b0, 1'b1, 8'h10, 16'h1000 + 16'(m_pc));
    checks++; if (halted !== 1'b0) $display("FAIL halt_exit: got %b want 0", halted); else passes++;
    checks++; if (pc !== 8'h10) $display("FAIL halt_resume_pc: got %h want 10", pc); else passes++;
    tick(1'b1, 1'b1, 1'b0, 8'h00, 16'h1000 + 16'(m_pc));
    checks++; if ({inst_out_valid, inst_out_pc} !== 9'h1_10) $display("FAIL halt_resume_out: got %b/%h want 1/10", inst_out_valid, inst_out_pc); else passes++;
  endtask

  task automatic test_reset_midstream();
    apply_reset(1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 8'h00, 16'h1000 + 16'(m_pc));
    tick(1'b1, 1'b1, 1'b0, 8'h00, 16'h1000 + 16'(m_pc));
    checks++; if (pc !== 8'h02) $display("FAIL rst_mid_fill: got pc %h want 02", pc); else passes++;
    apply_reset(1'b1, 1'b1);
    checks++; if (pc !== 8'h00) $display("FAIL rst_mid_pc: got %h want 00", pc); else passes++;
    checks++; if (inst_out_valid !== 1'b0) $display("FAIL rst_mid_valid: got %b want 0", inst_out_valid); else passes++;
    checks++; if (halted !== 1'b0) $display("FAIL rst_mid_halted: got %b want 0", halted); else passes++;
    tick(1'b1, 1'b1, 1'b0, 8'h00, 16'h1000 + 16'(m_pc));
    checks++; if ({inst_out_valid, inst_out, inst_out_pc} !== 25'h1_1000_00) $display("FAIL rst_mid_first: got %b/%h/%h want 1/1000/00", inst_out_valid, inst_out, inst_out_pc); else passes++;
  endtask

  initial begin
    reset         = 1'b1;
    inst_in       = '0;
    inst_in_valid = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = '0;
    m_pc          = 8'h00;
    m_halted      = 1'b0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_stall();
    test_branch();
    test_wrap();
    test_halt();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/inst_fetch_stage.md
Name: inst_fetch_stage

Overview:
- Fetch stage directly upstream of the processor core. Owns the program counter (pc) and accepts instruction words (inst_in) from instruction memory.
- Buffers fetched words in a small FIFO. Presents them, each tagged with its fetch PC, to the core as inst_out under a valid/stall handshake.
- Handles branch redirect (flush and reload of pc) and halt-on-HALT-opcode.

Parameters:
- PC_WIDTH, 8, width of pc and of all address fields.
- INST_WIDTH, 16, instruction word width.
- DEPTH, 2, fetch buffer entries (power of two, >=2).
- HALT_OPCODE, 4'hF, value of inst[15:12] that halts fetch.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- pc  output  PC_WIDTH  address currently requested from instruction memory.
- inst_in  input  INST_WIDTH  instruction word for address pc, valid in the same cycle.
- inst_in_valid  input  1  inst_in holds a valid word this cycle.
- inst_out  output  INST_WIDTH  head-of-buffer instruction to the core.
- inst_out_pc  output  PC_WIDTH  fetch address of inst_out.
- inst_out_valid  output  1  buffer non-empty; inst_out and inst_out_pc are meaningful.
- stall  input  1  core not accepting this cycle.
- branch_taken  input  1  redirect request from the core.
- branch_target  input  PC_WIDTH  redirect address.
- halted  output  1  fetch FSM is in HALTED.

Behaviour:
- Clock is clk. Reset is synchronous, active-high (reset), sampled on posedge clk.
- Reset values: pc=0, buffer empty (count=0), inst_out_valid=0, inst_out=0, inst_out_pc=0, halted=0, FSM=RUN.
- Reset asserted mid-operation discards all buffered words on that edge, regardless of other inputs.
- Outputs inst_out, inst_out_pc and inst_out_valid come from registers (buffer head). No combinational path from inst_in to inst_out.
- pop = inst_out_valid && !stall.
- push = FSM==RUN && inst_in_valid && !branch_taken && (count<DEPTH || pop).
- On push:
  - write {inst_in, pc} at the buffer tail.
  - pc <= pc+1, modulo 2^PC_WIDTH (8'hFF wraps to 8'h00).
- No push: pc holds.
- Simultaneous push and pop: count unchanged. Permitted when full (pop frees the slot in the same cycle).
- Push into an empty buffer: the word appears on inst_out on the next cycle (1-cycle fetch latency).
- pop when count=1 with no push: inst_out_valid=0 next cycle. inst_out and inst_out_pc hold their last values.
- inst_in_valid=1 while full and not popping: word is not taken, pc holds. The memory re-presents the same address next cycle.
- branch_taken=1 (highest priority after reset):
  - buffer flushed (count=0);
  - pc <= branch_target;
  - inst_in that cycle discarded;
  - any pop that cycle is ignored;
  - FSM <= RUN, halted <= 0.
- FSM RUN -> HALTED: on a push whose inst_in[15:12]==HALT_OPCODE.
  - The HALT word itself is buffered.
  - pc <= pc+1.
  - halted=1 from the next cycle.
- FSM HALTED:
  - no pushes, pc holds;
  - buffered words, including HALT, still drain normally via pop;
  - exit only via branch_taken or reset.
- Buffer is a circular FIFO with read/write pointers of log2(DEPTH) bits that wrap naturally. Count ranges 0..DEPTH.
- Read or write of X on inst_in when inst_in_valid=0 has no effect.

Test Plan:
- Reset, then inst_in_valid=1 with inst_in=16'h1000+pc for 6 cycles, stall=0 -> pc steps 0..6. From cycle 1, inst_out = 16'h1000..16'h1005 with inst_out_pc = 0..5, one per cycle, inst_out_valid continuous.
- Stream with stall=1 from cycle 2 for 4 cycles -> buffer fills to 2 and pc freezes at 3 while full. inst_out holds 16'h1001/pc=1 until stall drops, then the sequence resumes with no loss or duplication.
- Steady stream, then branch_taken=1 with branch_target=8'h40 while 2 words are buffered -> next cycle inst_out_valid=0, pc=8'h40. The next valid inst_out has inst_out_pc=8'h40, and no pre-branch word is ever popped.
- Load pc to 8'hFE via branch, then stream 3 words -> inst_out_pc sequence is 8'hFE, 8'hFF, 8'h00.
- inst_in=16'hF123 fetched at pc=5 -> halted=1 next cycle and pc stays 6 despite inst_in_valid=1. HALT drains as inst_out=16'hF123, inst_out_pc=5. Then branch_taken with target 8'h10 -> halted=0 and fetch resumes at 8'h10.
- Reset asserted for one cycle while the buffer is full and stall=1 -> next cycle pc=0, inst_out_valid=0, halted=0. The first post-reset word appears with inst_out_pc=0.
